regfile_wb_arbiter: RTL and testbench

Write-back arbiter that shares the register file's single write port between two producers. Port 0 is the in-order pipeline write-back stage. Port 1 is a multi-cycle unit such as mul/div or a miss-return path, and it is buffered in a 2-entry FIFO. The block drives the register file write port (load, dest, in) from registered outputs and exports a pending-destination mask that decode uses for hazard stalls. Port 0 has priority, bounded by a starvation limit that guarantees port 1 forward progress.

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter: shares the RF write port between pipeline WB and a
// FIFO-buffered multi-cycle unit, with a starvation bound. Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p0_valid_i,
  output logic        p0_ready_o,
  input  logic [4:0]  p0_dest_i,
  input  logic [31:0] p0_data_i,
  input  logic        p1_valid_i,
  output logic        p1_ready_o,
  input  logic [4:0]  p1_dest_i,
  input  logic [31:0] p1_data_i,
  output logic        rf_load_o,
  output logic [4:0]  rf_dest_o,
  output logic [31:0] rf_in_o,
  output logic [31:0] p1_pending_o
);

  localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

  logic [4:0]  dest_q [2];
  logic [31:0] data_q [2];
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_load_q, rf_load_d;
  logic [4:0]  rf_dest_q, rf_dest_d;
  logic [31:0] rf_in_q, rf_in_d;

  logic        force_w;
  logic        grant0_w;
  logic        grant1_w;
  logic        push_w;
  logic [1:0]  vld_w;
  logic [31:0] pend_w;

  assign force_w    = (count_q != 2'd0) && (starve_q == c_limit);
  assign grant1_w   = (count_q != 2'd0) && (force_w || !p0_valid_i);
  assign grant0_w   = !grant1_w && p0_valid_i;
  assign p1_ready_o = (count_q != 2'd2);
  assign p0_ready_o = !force_w;
  assign push_w     = p1_valid_i && p1_ready_o;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    starve_d  = starve_q;
    rf_load_d = 1'b0;
    rf_dest_d = rf_dest_q;
    rf_in_d   = rf_in_q;

    if (push_w) tail_d = !tail_q;
    if (grant1_w) head_d = !head_q;
    case ({push_w, grant1_w})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Saturating counter; any port-1 grant or an empty FIFO restarts the window.
    if (count_d == 2'd0 || grant1_w) begin
      starve_d = 4'd0;
    end else if (grant0_w && count_q != 2'd0 && starve_q != c_limit) begin
      starve_d = starve_q + 4'd1;
    end

    if (grant1_w) begin
      rf_load_d = (dest_q[head_q] != 5'd0);
      rf_dest_d = dest_q[head_q];
      rf_in_d   = data_q[head_q];
    end else if (grant0_w) begin
      rf_load_d = (p0_dest_i != 5'd0);
      rf_dest_d = p0_dest_i;
      rf_in_d   = p0_data_i;
    end
  end

  assign vld_w[0] = (count_q == 2'd2) || (count_q == 2'd1 && !head_q);
  assign vld_w[1] = (count_q == 2'd2) || (count_q == 2'd1 &&  head_q);

  always_comb begin
    pend_w = 32'd0;
    if (vld_w[0]) pend_w[dest_q[0]] = 1'b1;
    if (vld_w[1]) pend_w[dest_q[1]] = 1'b1;
    pend_w[0] = 1'b0;
  end

  assign p1_pending_o = pend_w;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      count_q   <= 2'd0;
      starve_q  <= 4'd0;
      rf_load_q <= 1'b0;
      rf_dest_q <= 5'd0;
      rf_in_q   <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        dest_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      rf_load_q <= rf_load_d;
      rf_dest_q <= rf_dest_d;
      rf_in_q   <= rf_in_d;
      if (push_w) begin
        dest_q[tail_q] <= p1_dest_i;
        data_q[tail_q] <= p1_data_i;
      end
    end
  end

  assign rf_load_o = rf_load_q;
  assign rf_dest_o = rf_dest_q;
  assign rf_in_o   = rf_in_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter: directed vector table plus multi-cycle sequences.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [4:0]  p0_dest, p1_dest;
  logic [31:0] p0_data, p1_data;
  logic        rf_load;
  logic [4:0]  rf_dest;
  logic [31:0] rf_in;
  logic [31:0] p1_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .p0_valid_i   (p0_valid),
    .p0_ready_o   (p0_ready),
    .p0_dest_i    (p0_dest),
    .p0_data_i    (p0_data),
    .p1_valid_i   (p1_valid),
    .p1_ready_o   (p1_ready),
    .p1_dest_i    (p1_dest),
    .p1_data_i    (p1_data),
    .rf_load_o    (rf_load),
    .rf_dest_o    (rf_dest),
    .rf_in_o      (rf_in),
    .p1_pending_o (p1_pending)
  );

  typedef struct {
    logic        p0v;
    logic [4:0]  p0d;
    logic [31:0] p0x;
    logic        p1v;
    logic [4:0]  p1d;
    logic [31:0] p1x;
    logic        e_p0r;
    logic        e_p1r;
    logic [31:0] e_pend;
    logic        e_load;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] d0, input logic [31:0] x0,
                       input logic v1, input logic [4:0] d1, input logic [31:0] x1);
    p0_valid = v0; p0_dest = d0; p0_data = x0;
    p1_valid = v1; p1_dest = d1; p1_data = x1;
  endtask

  task automatic do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int  n0;
    bit  found;
    bit  acc;
    bit  hs;
    int  got[$];

    // p0v p0d  p0x           p1v p1d    p1x         p0r p1r pend          load dest   data
    vecs[0]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,       1, 1, 32'h0,        0, 5'd0,  32'h0};
    vecs[1]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0,  32'h0,       1, 1, 32'h0,        1, 5'd5,  32'hDEADBEEF};
    vecs[2]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,       1, 1, 32'h0,        0, 5'd5,  32'hDEADBEEF};
    vecs[3]  = '{0, 5'd0, 32'h0,        1, 5'd7,  32'h12345678,1, 1, 32'h0,        0, 5'd5,  32'hDEADBEEF};
    vecs[4]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,       1, 1, 32'h80,       1, 5'd7,  32'h12345678};
    vecs[5]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,       1, 1, 32'h0,        0, 5'd7,  32'h12345678};
    vecs[6]  = '{1, 5'd0, 32'h11111111, 0, 5'd0,  32'h0,       1, 1, 32'h0,        0, 5'd0,  32'h11111111};
    vecs[7]  = '{0, 5'd0, 32'h0,        1, 5'd0,  32'h22222222,1, 1, 32'h0,        0, 5'd0,  32'h11111111};
    vecs[8]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,       1, 1, 32'h0,        0, 5'd0,  32'h22222222};
    vecs[9]  = '{0, 5'd0, 32'h0,        0, 5'd0,  32'h0,       1, 1, 32'h0,        0, 5'd0,  32'h22222222};
    vecs[10] = '{1, 5'd1, 32'hA,        1, 5'd31, 32'hB,       1, 1, 32'h0,        1, 5'd1,  32'hA};
    vecs[11] = '{1, 5'd2, 32'hC,        0, 5'd0,  32'h0,       1, 1, 32'h80000000, 1, 5'd2,  32'hC};
    vecs[12] = '{1, 5'd3, 32'hD,        1, 5'd4,  32'hE,       1, 1, 32'h80000000, 1, 5'd3,  32'hD};
    vecs[13] = '{1, 5'd5, 32'hF,        0, 5'd0,  32'h0,       1, 0, 32'h80000010, 1, 5'd5,  32'hF};
    vecs[14] = '{1, 5'd6, 32'h10,       0, 5'd0,  32'h0,       1, 0, 32'h80000010, 1, 5'd6,  32'h10};
    vecs[15] = '{1, 5'd8, 32'h20,       0, 5'd0,  32'h0,       0, 0, 32'h80000010, 1, 5'd31, 32'hB};
    vecs[16] = '{1, 5'd8, 32'h20,       0, 5'd0,  32'h0,       1, 1, 32'h10,       1, 5'd8,  32'h20};

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_load", {31'd0, rf_load}, 32'd0);
    chk("rst_dest", {27'd0, rf_dest}, 32'd0);
    chk("rst_in", rf_in, 32'd0);
    chk("rst_pend", p1_pending, 32'd0);
    chk("rst_p1_ready", {31'd0, p1_ready}, 32'd1);
    chk("rst_p0_ready", {31'd0, p0_ready}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].p0v, vecs[i].p0d, vecs[i].p0x, vecs[i].p1v, vecs[i].p1d, vecs[i].p1x);
      #1;
      chk($sformatf("vec%0d_p0_ready", i), {31'd0, p0_ready}, {31'd0, vecs[i].e_p0r});
      chk($sformatf("vec%0d_p1_ready", i), {31'd0, p1_ready}, {31'd0, vecs[i].e_p1r});
      chk($sformatf("vec%0d_pend", i), p1_pending, vecs[i].e_pend);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_load", i), {31'd0, rf_load}, {31'd0, vecs[i].e_load});
      chk($sformatf("vec%0d_dest", i), {27'd0, rf_dest}, {27'd0, vecs[i].e_dest});
      chk($sformatf("vec%0d_data", i), rf_in, vecs[i].e_data);
    end

    // Starvation bound: one queued entry against a continuously valid port 0.
    do_reset();
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'h33);
    #1;
    chk("starve_push_ready", {31'd0, p1_ready}, 32'd1);
    @(posedge clk);
    #1;
    n0 = 0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      drive(1'b1, 5'(21 + c), 32'(c), 1'b0, 5'd0, 32'd0);
      #1;
      if (!p0_ready) found = 1'b1;
      else if (p1_pending != 32'd0) n0++;
      @(posedge clk);
      #1;
      if (found) begin
        chk("starve_forced_load", {31'd0, rf_load}, 32'd1);
        chk("starve_forced_dest", {27'd0, rf_dest}, 32'd3);
        chk("starve_forced_data", rf_in, 32'h33);
      end
    end
    chk("starve_found", {31'd0, found}, 32'd1);
    chk("starve_p0_grants", n0, 32'd4);
    drive(1'b1, 5'd17, 32'h77, 1'b0, 5'd0, 32'd0);
    #1;
    chk("starve_resume_ready", {31'd0, p0_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("starve_resume_dest", {27'd0, rf_dest}, 32'd17);

    // FIFO full: two entries, a third stalls until the first pop; order kept.
    do_reset();
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'd9);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd10, 32'd10);
    #1;
    chk("full_second_ready", {31'd0, p1_ready}, 32'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd11, 32'd11);
    #1;
    chk("full_p1_ready", {31'd0, p1_ready}, 32'd0);
    chk("full_pend", p1_pending, 32'h600);
    acc = 1'b0;
    for (int c = 0; c < 40 && got.size() < 3; c++) begin
      drive(1'b1, 5'd20, 32'h20, !acc, 5'd11, 32'd11);
      #1;
      hs = p1_valid && p1_ready;
      if (hs) chk("full_third_pend", p1_pending, 32'h400);
      @(posedge clk);
      #1;
      if (hs) acc = 1'b1;
      if (rf_load && rf_dest != 5'd20) got.push_back(int'(rf_dest));
    end
    chk("full_accepted", {31'd0, acc}, 32'd1);
    chk("full_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("full_order0", got[0], 32'd9);
      chk("full_order1", got[1], 32'd10);
      chk("full_order2", got[2], 32'd11);
    end

    // Asynchronous reset mid-operation with two entries queued.
    do_reset();
    drive(1'b1, 5'd20, 32'h55, 1'b1, 5'd12, 32'd12);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd20, 32'h55, 1'b1, 5'd13, 32'd13);
    @(posedge clk);
    #1;
    chk("mid_pre_load", {31'd0, rf_load}, 32'd1);
    chk("mid_pre_pend", p1_pending, 32'h3000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_load", {31'd0, rf_load}, 32'd0);
    chk("mid_rst_dest", {27'd0, rf_dest}, 32'd0);
    chk("mid_rst_in", rf_in, 32'd0);
    chk("mid_rst_pend", p1_pending, 32'd0);
    chk("mid_rst_p1_ready", {31'd0, p1_ready}, 32'd1);
    chk("mid_rst_p0_ready", {31'd0, p0_ready}, 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_load%0d", c), {31'd0, rf_load}, 32'd0);
      chk($sformatf("post_rst_pend%0d", c), p1_pending, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
